word32_8bits_arbiter: RTL and testbench

//  Two-requester round-robin scheduler for the 32->8 bit byte serializer in the clk_4f domain.

---
 rtl/word32_8bits_pkg.sv | 30 +++
 rtl/word32_8bits_slicer.sv | 31 +++
 rtl/word32_8bits_arbiter.sv | 77 +++++++
 tb/tb_word32_8bits_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word32_8bits_pkg.sv
// Shared types and constants for the two-lane 32->8 byte serializer.
// FSM encoding, last slot index and the idle byte default live here.
package word32_8bits_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [1:0] SLOT_LAST     = 2'd3;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;

  // Slot 0 is the MSB of the word.
  function automatic logic [7:0] pick_byte(
    input logic [31:0] w,
    input logic [1:0]  s
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (s)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/word32_8bits_slicer.sv
// Word register, 2-bit slot counter and byte mux.
// load restarts at slot 0; advance steps to the next byte.
module word32_8bits_slicer
  import word32_8bits_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] word_in,
  output logic [1:0]  slot,
  output logic [7:0]  byte_out
);

  logic [31:0] word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= 32'h0;
      slot   <= 2'd0;
    end else if (load) begin
      word_q <= word_in;
      slot   <= 2'd0;
    end else if (advance) begin
      slot <= slot + 2'd1;
    end
  end

  assign byte_out = pick_byte(word_q, slot);

endmodule

// File: rtl/word32_8bits_arbiter.sv
// Two-lane round-robin word arbiter feeding a 32->8 serializer.
// Words stream back-to-back when a grant lands on the last slot.
module word32_8bits_arbiter
  import word32_8bits_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEF,
  parameter logic       FIRST_LANE = 1'b0
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        valid_in0,
  input  logic [31:0] Data_in0,
  output logic        ready_out0,
  input  logic        valid_in1,
  input  logic [31:0] Data_in1,
  output logic        ready_out1,
  output logic        valid_out,
  output logic [7:0]  Data_out,
  output logic        lane_out,
  output logic        busy
);

  state_t      state;
  logic        rr_ptr;
  logic        lane_q;
  logic [1:0]  slot;
  logic [7:0]  cur_byte;
  logic        can_accept;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        last_slot;
  logic [31:0] word_sel;

  assign last_slot  = (slot == SLOT_LAST);
  assign can_accept = (state == ST_IDLE) ||
                      (state == ST_SEND && last_slot);

  // A lone requester wins regardless of rr_ptr.
  assign grant0 = valid_in0 & (~valid_in1 | ~rr_ptr);
  assign grant1 = valid_in1 & (~valid_in0 |  rr_ptr);

  assign ready_out0 = can_accept & grant0 & ~reset;
  assign ready_out1 = can_accept & grant1 & ~reset;
  assign accept     = ready_out0 | ready_out1;
  assign word_sel   = ready_out1 ? Data_in1 : Data_in0;

  word32_8bits_slicer u_slicer (
    .clk      (clk_4f),
    .reset    (reset),
    .load     (accept),
    .advance  (state == ST_SEND && !last_slot),
    .word_in  (word_sel),
    .slot     (slot),
    .byte_out (cur_byte)
  );

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state  <= ST_IDLE;
      rr_ptr <= FIRST_LANE;
      lane_q <= 1'b0;
    end else if (accept) begin
      state  <= ST_SEND;
      rr_ptr <= ~ready_out1;
      lane_q <= ready_out1;
    end else if (state == ST_SEND && last_slot) begin
      state <= ST_IDLE;
    end
  end

  assign valid_out = (state == ST_SEND);
  assign busy      = (state == ST_SEND);
  assign Data_out  = valid_out ? cur_byte : IDLE_BYTE;
  assign lane_out  = lane_q;

endmodule

// File: tb/tb_word32_8bits_arbiter.sv
// Bench for the two-lane word serializer, driven by a byte-queue
// reference model of the round-robin scheduling rules.
module tb_word32_8bits_arbiter;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic        valid_in0, valid_in1;
  logic [31:0] Data_in0, Data_in1;
  logic        ready_out0, ready_out1;
  logic        valid_out, lane_out, busy;
  logic [7:0]  Data_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  bit         m_rr;
  bit         m_lane;
  logic [7:0] cap_b[$];
  bit         cap_l[$];
  bit         acc0, acc1;
  int         r0_cnt, r1_cnt;

  word32_8bits_arbiter dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .valid_in0  (valid_in0),
    .Data_in0   (Data_in0),
    .ready_out0 (ready_out0),
    .valid_in1  (valid_in1),
    .Data_in1   (Data_in1),
    .ready_out1 (ready_out1),
    .valid_out  (valid_out),
    .Data_out   (Data_out),
    .lane_out   (lane_out),
    .busy       (busy)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic cycle();
    bit can, e_r0, e_r1, e_v;
    logic [7:0] e_d;
    logic [31:0] w;
    @(negedge clk_4f);
    can  = (mq.size() <= 1) && !reset;
    e_r0 = can && valid_in0 && (!valid_in1 || !m_rr);
    e_r1 = can && valid_in1 && (!valid_in0 || m_rr);
    e_v  = (mq.size() != 0);
    e_d  = e_v ? mq[0] : 8'h00;
    n_cmp++;
    if (ready_out0 !== e_r0) begin
      n_err++;
      $display("FAIL ready_out0 got=%b exp=%b t=%0t", ready_out0, e_r0, $time);
    end
    n_cmp++;
    if (ready_out1 !== e_r1) begin
      n_err++;
      $display("FAIL ready_out1 got=%b exp=%b t=%0t", ready_out1, e_r1, $time);
    end
    n_cmp++;
    if (valid_out !== e_v) begin
      n_err++;
      $display("FAIL valid_out got=%b exp=%b t=%0t", valid_out, e_v, $time);
    end
    n_cmp++;
    if (Data_out !== e_d) begin
      n_err++;
      $display("FAIL Data_out got=%h exp=%h t=%0t", Data_out, e_d, $time);
    end
    n_cmp++;
    if (lane_out !== m_lane) begin
      n_err++;
      $display("FAIL lane_out got=%b exp=%b t=%0t", lane_out, m_lane, $time);
    end
    n_cmp++;
    if (busy !== e_v) begin
      n_err++;
      $display("FAIL busy got=%b exp=%b t=%0t", busy, e_v, $time);
    end
    if (valid_out === 1'b1) begin
      cap_b.push_back(Data_out);
      cap_l.push_back(lane_out);
    end
    if (e_r0) r0_cnt++;
    if (e_r1) r1_cnt++;
    acc0 = e_r0;
    acc1 = e_r1;
    @(posedge clk_4f);
    if (reset) begin
      mq.delete();
      m_rr   = 1'b0;
      m_lane = 1'b0;
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (e_r0 || e_r1) begin
        w = e_r1 ? Data_in1 : Data_in0;
        mq.push_back(w[31:24]);
        mq.push_back(w[23:16]);
        mq.push_back(w[15:8]);
        mq.push_back(w[7:0]);
        m_lane = e_r1;
        m_rr   = !e_r1;
      end
    end
    #1;
  endtask

  task automatic drain();
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic clear_cap();
    cap_b.delete();
    cap_l.delete();
    r0_cnt = 0;
    r1_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in0 = 1'b1;
    valid_in1 = 1'b1;
    Data_in0 = 32'h11111111;
    Data_in1 = 32'h22222222;
    @(posedge clk_4f);
    #1;
    mq.delete();
    m_rr = 1'b0;
    m_lane = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b0;
    drain();
  endtask

  task automatic test_single();
    logic [7:0] exp_b[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_cap();
    valid_in0 = 1'b1;
    Data_in0 = 32'hDEADBEEF;
    cycle();
    valid_in0 = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    n_cmp++;
    if (cap_b.size() != 4) begin
      n_err++;
      $display("FAIL single_len got=%0d exp=4", cap_b.size());
    end
    for (int i = 0; i < 4 && i < cap_b.size(); i++) begin
      n_cmp++;
      if (cap_b[i] !== exp_b[i] || cap_l[i] !== 1'b0) begin
        n_err++;
        $display("FAIL single_byte%0d got=%h/%b exp=%h/0",
                 i, cap_b[i], cap_l[i], exp_b[i]);
      end
    end
    n_cmp++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle got=%b%b exp=00", valid_out, busy);
    end
  endtask

  task automatic test_alternate();
    bit gl[$];
    int gc[$];
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    clear_cap();
    valid_in0 = 1'b1;
    valid_in1 = 1'b1;
    Data_in0 = 32'h11223344;
    Data_in1 = 32'hAABBCCDD;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (acc0 || acc1) begin
        gl.push_back(acc1);
        gc.push_back(i);
      end
    end
    drain();
    n_cmp++;
    if (gl.size() != 4) begin
      n_err++;
      $display("FAIL alt_grants got=%0d exp=4", gl.size());
    end
    for (int i = 0; i < gl.size(); i++) begin
      n_cmp++;
      if (gl[i] !== i[0] || gc[i] != 4 * i) begin
        n_err++;
        $display("FAIL alt_grant%0d got=lane%0d@%0d exp=lane%0d@%0d",
                 i, gl[i], gc[i], i[0], 4 * i);
      end
    end
    n_cmp++;
    if (cap_b.size() != 16 || cap_b[4] !== 8'hAA || cap_b[11] !== 8'h44) begin
      n_err++;
      $display("FAIL alt_bytes got=%0d bytes", cap_b.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[8] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0,
                             8'h01, 8'h02, 8'h03, 8'h04};
    bit r1s[4];
    clear_cap();
    valid_in0 = 1'b1;
    Data_in0 = 32'hA0B0C0D0;
    cycle();
    valid_in0 = 1'b0;
    valid_in1 = 1'b1;
    Data_in1 = 32'h01020304;
    for (int i = 0; i < 4; i++) begin
      cycle();
      r1s[i] = acc1;
    end
    valid_in1 = 1'b0;
    drain();
    n_cmp++;
    if (r1s[0] || r1s[1] || r1s[2] || !r1s[3]) begin
      n_err++;
      $display("FAIL b2b_ready1 got=%b%b%b%b exp=0001",
               r1s[0], r1s[1], r1s[2], r1s[3]);
    end
    n_cmp++;
    if (cap_b.size() != 8) begin
      n_err++;
      $display("FAIL b2b_len got=%0d exp=8", cap_b.size());
    end
    for (int i = 0; i < 8 && i < cap_b.size(); i++) begin
      n_cmp++;
      if (cap_b[i] !== exp_b[i] || cap_l[i] !== (i >= 4)) begin
        n_err++;
        $display("FAIL b2b_byte%0d got=%h exp=%h", i, cap_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b[4] = '{8'h55, 8'hAA, 8'h55, 8'hAA};
    valid_in0 = 1'b1;
    Data_in0 = 32'hCAFEF00D;
    cycle();
    valid_in0 = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    n_cmp++;
    if (valid_out !== 1'b0 || Data_out !== 8'h00) begin
      n_err++;
      $display("FAIL rst_mid got=%b/%h exp=0/00", valid_out, Data_out);
    end
    reset = 1'b0;
    clear_cap();
    valid_in0 = 1'b1;
    Data_in0 = 32'h55AA55AA;
    cycle();
    valid_in0 = 1'b0;
    drain();
    n_cmp++;
    if (cap_b.size() != 4) begin
      n_err++;
      $display("FAIL rst_len got=%0d exp=4", cap_b.size());
    end
    for (int i = 0; i < 4 && i < cap_b.size(); i++) begin
      n_cmp++;
      if (cap_b[i] !== exp_b[i]) begin
        n_err++;
        $display("FAIL rst_byte%0d got=%h exp=%h", i, cap_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_drop();
    clear_cap();
    valid_in1 = 1'b1;
    Data_in1 = 32'h13572468;
    cycle();
    valid_in1 = 1'b0;
    cycle();
    valid_in0 = 1'b1;
    Data_in0 = 32'h99999999;
    cycle();
    valid_in0 = 1'b0;
    drain();
    n_cmp++;
    if (cap_b.size() != 4 || r0_cnt != 0 || cap_b[3] !== 8'h68) begin
      n_err++;
      $display("FAIL drop got=%0d bytes r0=%0d exp=4 bytes r0=0",
               cap_b.size(), r0_cnt);
    end
    clear_cap();
    valid_in0 = 1'b1;
    Data_in0 = 32'h0BADF00D;
    cycle();
    valid_in0 = 1'b0;
    drain();
    n_cmp++;
    if (cap_b.size() != 4 || cap_b[0] !== 8'h0B || cap_l[0] !== 1'b0) begin
      n_err++;
      $display("FAIL drop_next got=%0d bytes exp=4 from 0B", cap_b.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle();
      reset = ($urandom_range(0, 99) == 0);
      if (acc0 || !valid_in0) begin
        valid_in0 = $urandom_range(0, 2) != 0;
        Data_in0 = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        valid_in0 = 1'b0;
      end
      if (acc1 || !valid_in1) begin
        valid_in1 = $urandom_range(0, 2) != 0;
        Data_in1 = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        valid_in1 = 1'b0;
      end
    end
    reset = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
